mem_array_sink: RTL and testbench

// - Receiving end of the row stream from the memory-array generator: accepts M rows of 16*N bits
//   per job index and assembles them into a double-buffered (2-bank) row array.
// - Hands each completed bank to the downstream mem-hash loop, which reads rows by address.
// - The downstream releases the bank when finished; that release frees it for the next job.

---
 rtl/mem_array_sink.sv | 181 ++++++++++++++++++
 tb/tb_mem_array_sink.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_array_sink.sv
// mem_array_sink: double-buffered row-array sink between the array generator
// and the mem-hash loop.
//
// Ports: clk, rst_n (async, active low)
//   in_valid/in_ready/in_addr/in_data/in_index : row stream in
//   arr_valid/arr_index : a complete bank is readable, and its job index
//   rd_en/rd_addr -> rd_data/rd_valid : registered row read
//   arr_release : downstream is done with the readable bank
//   err[0] bad/duplicate address, err[1] index mismatch (sticky)
// Option: MEM_ARRAY_SINK_BITMAP_EN -> completion on all M distinct addresses.
module mem_array_sink #(
  parameter int N        = 32,
  parameter int M        = 32,
  parameter int ID_WIDTH = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [16*N-1:0]     in_data,
  input  logic [ID_WIDTH-1:0] in_index,
  output logic                arr_valid,
  output logic [ID_WIDTH-1:0] arr_index,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [16*N-1:0]     rd_data,
  output logic                rd_valid,
  input  logic                arr_release,
  output logic [1:0]          err
);

  localparam int W  = 16 * N;
  localparam int D  = 2 ** ADDR_W;
  localparam int CW = $clog2(M + 1);
  localparam logic [ADDR_W:0] M_A = (ADDR_W + 1)'(M);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bst_e;

  bst_e                st_q  [2];
  bst_e                st_d  [2];
  logic [ID_WIDTH-1:0] idx_q [2];
  logic [ID_WIDTH-1:0] idx_d [2];

  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic in_ready_q, in_ready_d;
  logic arr_valid_q, arr_valid_d;
  logic [ID_WIDTH-1:0] arr_index_q, arr_index_d;
  logic rd_valid_q;
  logic [W-1:0] rd_data_q;
  logic [1:0] err_q, err_d;

  logic acc, addr_ok, wr_en, done, rel, rd_acc;

  logic [W-1:0] mem_q [2][D];

`ifdef MEM_ARRAY_SINK_BITMAP_EN
  // Only the bank being filled needs tracking; it clears on completion.
  logic [D-1:0] bmap_q, bmap_d, bmap_n;
`else
  localparam logic [CW-1:0] M_C = CW'(M);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    err_d     = err_q;
    done      = 1'b0;
    acc       = in_valid && in_ready_q;
    addr_ok   = {1'b0, in_addr} < M_A;
    wr_en     = acc && addr_ok;
    rel       = arr_release && arr_valid_q;
    rd_acc    = rd_en && arr_valid_q;
`ifdef MEM_ARRAY_SINK_BITMAP_EN
    bmap_d    = bmap_q;
    bmap_n    = bmap_q;
`else
    cnt_d     = cnt_q;
`endif

    if (acc && !addr_ok) err_d[0] = 1'b1;

    if (wr_en) begin
      if (st_q[wr_bank_q] == EMPTY) begin
        st_d[wr_bank_q]  = FILLING;
        idx_d[wr_bank_q] = in_index;
      end else if (in_index != idx_q[wr_bank_q]) begin
        err_d[1] = 1'b1;
      end
`ifdef MEM_ARRAY_SINK_BITMAP_EN
      if (bmap_q[in_addr]) err_d[0] = 1'b1;
      bmap_n = bmap_q | (D'(1) << in_addr);
      bmap_d = bmap_n;
      done   = &bmap_n[M-1:0];
`else
      cnt_d = cnt_q + CW'(1);
      done  = (cnt_d == M_C);
`endif
    end

    if (done) begin
      st_d[wr_bank_q] = FULL;
      wr_bank_d       = ~wr_bank_q;
`ifdef MEM_ARRAY_SINK_BITMAP_EN
      bmap_d = '0;
`else
      cnt_d  = '0;
`endif
    end

    // Release always targets the readable bank, never the one being filled.
    if (rel) begin
      st_d[rd_bank_q] = EMPTY;
      rd_bank_d       = ~rd_bank_q;
    end

    in_ready_d  = (st_d[wr_bank_d] != FULL);
    // A release forces one idle cycle before the other bank is presented.
    arr_valid_d = !rel && (st_d[rd_bank_d] == FULL);
    arr_index_d = arr_valid_d ? idx_d[rd_bank_d] : arr_index_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      idx_q[0]    <= '0;
      idx_q[1]    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      arr_valid_q <= 1'b0;
      arr_index_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      err_q       <= '0;
`ifdef MEM_ARRAY_SINK_BITMAP_EN
      bmap_q      <= '0;
`else
      cnt_q       <= '0;
`endif
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      in_ready_q  <= in_ready_d;
      arr_valid_q <= arr_valid_d;
      arr_index_q <= arr_index_d;
      rd_valid_q  <= rd_acc;
      err_q       <= err_d;
      if (rd_acc) rd_data_q <= mem_q[rd_bank_q][rd_addr];
`ifdef MEM_ARRAY_SINK_BITMAP_EN
      bmap_q      <= bmap_d;
`else
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank_q][in_addr] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign arr_valid = arr_valid_q;
  assign arr_index = arr_index_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_array_sink.sv
// tb_mem_array_sink: randomized scenarios for mem_array_sink checked
// against a queue-of-completed-jobs reference model.
module tb_mem_array_sink;

  localparam int N  = 32;
  localparam int M  = 32;
  localparam int IW = 32;
  localparam int AW = 6;
  localparam int W  = 16 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [W-1:0]  in_data = '0;
  logic [IW-1:0] in_index = '0;
  logic          arr_valid;
  logic [IW-1:0] arr_index;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          arr_release = 1'b0;
  logic [1:0]    err;

  always #5 clk = ~clk;

  mem_array_sink #(
    .N(N), .M(M), .ID_WIDTH(IW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .in_index(in_index),
    .arr_valid(arr_valid), .arr_index(arr_index),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .arr_release(arr_release), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completed jobs in arrival order, plus the job in progress.
  logic [IW-1:0] fq_idx [$];
  logic [W-1:0]  fq_data [$];
  logic [W-1:0]  cur_rows [M];
  bit            cur_seen [M];
  int            cur_cnt;
  bit            cur_started;
  logic [IW-1:0] cur_idx;
  logic [1:0]    exp_err;
  logic [W-1:0]  last_rd;
  int            perm [M];

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic void cur_clear();
    cur_cnt = 0;
    cur_started = 1'b0;
    cur_idx = '0;
    for (int r = 0; r < M; r++) cur_seen[r] = 1'b0;
  endfunction

  function automatic void model_reset();
    fq_idx.delete();
    fq_data.delete();
    exp_err = '0;
    cur_clear();
  endfunction

  function automatic void model_accept(input logic [AW-1:0] a,
                                       input logic [IW-1:0] ix,
                                       input logic [W-1:0] d);
    int ai;
    bit fin;
    ai = int'(a);
    if (ai >= M) begin
      exp_err[0] = 1'b1;
      return;
    end
    if (!cur_started) begin
      cur_started = 1'b1;
      cur_idx = ix;
    end else if (ix != cur_idx) begin
      exp_err[1] = 1'b1;
    end
`ifdef MEM_ARRAY_SINK_BITMAP_EN
    if (cur_seen[ai]) exp_err[0] = 1'b1;
    cur_seen[ai] = 1'b1;
    cur_rows[ai] = d;
    fin = 1'b1;
    for (int r = 0; r < M; r++) if (!cur_seen[r]) fin = 1'b0;
`else
    cur_seen[ai] = 1'b1;
    cur_rows[ai] = d;
    cur_cnt++;
    fin = (cur_cnt == M);
`endif
    if (fin) begin
      fq_idx.push_back(cur_idx);
      for (int r = 0; r < M; r++) fq_data.push_back(cur_rows[r]);
      cur_clear();
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mkperm();
    int j, t;
    for (int i = 0; i < M; i++) perm[i] = i;
    for (int i = M - 1; i > 0; i--) begin
      j = $urandom_range(i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
  endtask

  task automatic send_row(input logic [AW-1:0] a,
                          input logic [IW-1:0] ix,
                          input logic [W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_index = ix;
    in_data  = d;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait addr %0d: in_ready got %b required 1", a, in_ready);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    model_accept(a, ix, d);
  endtask

  task automatic send_job(input logic [IW-1:0] ix);
    mkperm();
    for (int i = 0; i < M; i++) send_row(AW'(perm[i]), ix, rnd_row());
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rel();
    arr_release = 1'b1;
    tick();
    arr_release = 1'b0;
    if (fq_idx.size() > 0) begin
      void'(fq_idx.pop_front());
      for (int r = 0; r < M; r++) void'(fq_data.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    checks++;
    if ({in_ready, arr_valid, arr_index, rd_valid, err} !== '0) begin
      errors++;
      $display("FAIL rst_ctrl got rdy=%b av=%b idx=%h rv=%b err=%b required all 0",
               in_ready, arr_valid, arr_index, rd_valid, err);
    end
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL rst_rd_data got %h required 0", rd_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after got %b required 1", in_ready);
    end
    last_rd = '0;
  endtask

  task automatic test_basic();
    int t;
    int a;
    for (int i = 0; i < M; i++) send_row(AW'(i), 32'h55, {16{32'(i)}});
    t = 0;
    while (!arr_valid && t < 2) begin
      tick();
      t++;
    end
    checks++;
    if (arr_valid !== 1'b1 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL basic_complete got av=%b idx=%h required av=1 idx=%h",
               arr_valid, arr_index, fq_idx[0]);
    end
    rd(7);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== fq_data[7]) begin
      errors++;
      $display("FAIL basic_rd7 got rv=%b data=%h required rv=1 data=%h",
               rd_valid, rd_data, fq_data[7]);
    end
    last_rd = fq_data[7];
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
      errors++;
      $display("FAIL basic_rd_idle got rv=%b data=%h required rv=0 data=%h",
               rd_valid, rd_data, last_rd);
    end
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(M - 1);
      rd_en = 1'b1;
      rd_addr = AW'(a);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== fq_data[a]) begin
        errors++;
        $display("FAIL basic_stream addr %0d got rv=%b data=%h required rv=1 data=%h",
                 a, rd_valid, rd_data, fq_data[a]);
      end
      last_rd = fq_data[a];
    end
    rd_en = 1'b0;
    rel();
    checks++;
    if (arr_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got av=%b required 0", arr_valid);
    end
    tick();
    rd(3);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
      errors++;
      $display("FAIL basic_rd_novalid got rv=%b data=%h required rv=0 data=%h",
               rd_valid, rd_data, last_rd);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    send_job(32'd1);
    send_job(32'd2);
    checks++;
    if (in_ready !== 1'b0 || arr_valid !== 1'b1 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL b2b_both_full got rdy=%b av=%b idx=%h required rdy=0 av=1 idx=%h",
               in_ready, arr_valid, arr_index, fq_idx[0]);
    end
    mkperm();
    in_valid = 1'b1;
    in_addr  = AW'(perm[0]);
    in_index = 32'd3;
    in_data  = rnd_row();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (in_ready !== 1'b0 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL b2b_stall got rdy=%b idx=%h required rdy=0 idx=%h",
               in_ready, arr_index, fq_idx[0]);
    end
    rel();
    in_valid = 1'b0;
    checks++;
    if (arr_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release got av=%b rdy=%b required av=0 rdy=1",
               arr_valid, in_ready);
    end
    tick();
    checks++;
    if (arr_valid !== 1'b1 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL b2b_next got av=%b idx=%h required av=1 idx=%h",
               arr_valid, arr_index, fq_idx[0]);
    end
    send_job(32'd3);
    checks++;
    if (in_ready !== 1'b0 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL b2b_job3_full got rdy=%b idx=%h required rdy=0 idx=%h",
               in_ready, arr_index, fq_idx[0]);
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(M - 1);
      rd(a);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== fq_data[a]) begin
        errors++;
        $display("FAIL b2b_rd_job2 addr %0d got %h required %h", a, rd_data, fq_data[a]);
      end
    end
    rel();
    tick();
    checks++;
    if (arr_valid !== 1'b1 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL b2b_job3_valid got av=%b idx=%h required av=1 idx=%h",
               arr_valid, arr_index, fq_idx[0]);
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(M - 1);
      rd(a);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== fq_data[a]) begin
        errors++;
        $display("FAIL b2b_rd_job3 addr %0d got %h required %h", a, rd_data, fq_data[a]);
      end
    end
    rel();
    tick();
  endtask

  task automatic test_errors();
    int t;
    logic [W-1:0] odd_row;
    mkperm();
    for (int i = 0; i < 16; i++) send_row(AW'(perm[i]), 32'd8, rnd_row());
    send_row(AW'(40), 32'd8, rnd_row());
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err_addr got %b required %b", err, exp_err);
    end
    odd_row = rnd_row();
    send_row(AW'(perm[16]), 32'd9, odd_row);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err_index got %b required %b", err, exp_err);
    end
    for (int i = 17; i < M - 1; i++) send_row(AW'(perm[i]), 32'd8, rnd_row());
    tick();
    checks++;
    if (arr_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_early_done got av=%b required 0", arr_valid);
    end
    send_row(AW'(perm[M-1]), 32'd8, rnd_row());
    t = 0;
    while (!arr_valid && t < 2) begin
      tick();
      t++;
    end
    checks++;
    if (arr_valid !== 1'b1 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL err_done got av=%b idx=%h required av=1 idx=%h",
               arr_valid, arr_index, fq_idx[0]);
    end
    rd(perm[16]);
    checks++;
    if (rd_data !== odd_row) begin
      errors++;
      $display("FAIL err_row_kept got %h required %h", rd_data, odd_row);
    end
    rel();
    tick();
  endtask

  task automatic test_simul();
    logic [W-1:0] d;
    int bad;
    send_job(32'h21);
    mkperm();
    for (int i = 0; i < M - 1; i++) send_row(AW'(perm[i]), 32'h22, rnd_row());
    d = rnd_row();
    in_valid = 1'b1;
    in_addr = AW'(perm[M-1]);
    in_index = 32'h22;
    in_data = d;
    arr_release = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || arr_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_pre got rdy=%b av=%b required 1 1", in_ready, arr_valid);
    end
    tick();
    in_valid = 1'b0;
    arr_release = 1'b0;
    void'(fq_idx.pop_front());
    for (int r = 0; r < M; r++) void'(fq_data.pop_front());
    model_accept(AW'(perm[M-1]), 32'h22, d);
    checks++;
    if (arr_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_edge got av=%b rdy=%b required av=0 rdy=1",
               arr_valid, in_ready);
    end
    tick();
    checks++;
    if (arr_valid !== 1'b1 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL simul_next got av=%b idx=%h required av=1 idx=%h",
               arr_valid, arr_index, fq_idx[0]);
    end
    bad = 0;
    for (int r = 0; r < M; r++) begin
      rd_en = 1'b1;
      rd_addr = AW'(r);
      tick();
      if (rd_valid !== 1'b1 || rd_data !== fq_data[r]) bad++;
    end
    rd_en = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL simul_rows got %0d bad rows required 0", bad);
    end
    rel();
    tick();
  endtask

  task automatic test_reset_midfill();
    int t;
    int a;
    for (int i = 0; i < 10; i++) send_row(AW'(i), 32'h77, rnd_row());
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({in_ready, arr_valid, arr_index, rd_valid, err} !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL midrst_outs got rdy=%b av=%b idx=%h rv=%b err=%b required all 0",
               in_ready, arr_valid, arr_index, rd_valid, err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready got %b required 1", in_ready);
    end
    send_job($urandom);
    t = 0;
    while (!arr_valid && t < 2) begin
      tick();
      t++;
    end
    checks++;
    if (arr_valid !== 1'b1 || arr_index !== fq_idx[0] || err !== exp_err) begin
      errors++;
      $display("FAIL midrst_job got av=%b idx=%h err=%b required av=1 idx=%h err=%b",
               arr_valid, arr_index, err, fq_idx[0], exp_err);
    end
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(M - 1);
      rd(a);
      checks++;
      if (rd_data !== fq_data[a]) begin
        errors++;
        $display("FAIL midrst_rd addr %0d got %h required %h", a, rd_data, fq_data[a]);
      end
    end
    rel();
    tick();
  endtask

`ifdef MEM_ARRAY_SINK_BITMAP_EN
  task automatic test_bitmap();
    int t;
    for (int i = 0; i < M - 1; i++) send_row(AW'(i), 32'h5b, rnd_row());
    send_row(AW'(5), 32'h5b, rnd_row());
    tick();
    tick();
    checks++;
    if (arr_valid !== 1'b0 || err !== exp_err) begin
      errors++;
      $display("FAIL bmap_dup got av=%b err=%b required av=0 err=%b",
               arr_valid, err, exp_err);
    end
    send_row(AW'(M - 1), 32'h5b, rnd_row());
    t = 0;
    while (!arr_valid && t < 2) begin
      tick();
      t++;
    end
    checks++;
    if (arr_valid !== 1'b1 || arr_index !== fq_idx[0]) begin
      errors++;
      $display("FAIL bmap_done got av=%b idx=%h required av=1 idx=%h",
               arr_valid, arr_index, fq_idx[0]);
    end
    rd(5);
    checks++;
    if (rd_data !== fq_data[5]) begin
      errors++;
      $display("FAIL bmap_rd5 got %h required %h", rd_data, fq_data[5]);
    end
    rel();
    tick();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_simul();
    test_reset_midfill();
`ifdef MEM_ARRAY_SINK_BITMAP_EN
    test_bitmap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
